wb_master_arbiter: RTL and testbench
====================================

Name: wb_master_arbiter

Overview:
- Shares the single Wishbone IO master port of the interconnect between several bus masters: core data port (master 0), JTAG debug module (master 1), and further masters if added.
- Grants on a round-robin basis, one whole bus cycle (cyc held high) at a time.
- Aborts any slave that never answers, using a watchdog timeout that returns err to the requesting master.
- Sits between the masters and the wb_io_* port of the interconnect.

Parameters:
- NUM_MASTERS, 2: number of requesting masters; legal range 2..8.
- TIMEOUT_CYCLES, 1024: cycles stb may stay unanswered before abort; 0 disables the watchdog.

Ports:
- wb_clk_i  in  1  bus clock
- wb_rst_i  in  1  synchronous reset, active-high
- wbm_adr_i  in  NUM_MASTERS*32  master addresses, master i at [32i+31:32i]
- wbm_dat_i  in  NUM_MASTERS*32  master write data
- wbm_sel_i  in  NUM_MASTERS*4  master byte selects
- wbm_we_i / wbm_cyc_i / wbm_stb_i  in  NUM_MASTERS each  master control
- wbm_dat_o  out  NUM_MASTERS*32  read data per master
- wbm_ack_o / wbm_err_o / wbm_rty_o  out  NUM_MASTERS each  responses per master
- wbs_adr_o / wbs_dat_o  out  32  to interconnect
- wbs_sel_o  out  4
- wbs_we_o / wbs_cyc_o / wbs_stb_o  out  1
- wbs_dat_i  in  32  from interconnect
- wbs_ack_i / wbs_err_i / wbs_rty_i  in  1
- grant_o  out  NUM_MASTERS  one-hot current grant, 0 when idle
- timeout_o  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset:
  - state=IDLE, grant_o=0, rr pointer=0, watchdog count=0.
  - All wbs_* outputs 0; all wbm_*_o outputs 0; timeout_o=0.
  - Reset mid-transfer drops cyc/stb at the next edge. No response is generated.
- IDLE:
  - If any wbm_cyc_i is high, select the first requester at or after the rr pointer (wrapping modulo NUM_MASTERS).
  - The grant is registered: the state becomes BUSY next cycle, giving 1 cycle arbitration latency.
  - Slave outputs stay 0 while in IDLE.
- BUSY:
  - wbs_adr/dat/sel/we/cyc/stb are combinational copies of the granted master's inputs.
  - wbs_ack/err/rty/dat are routed only to the granted master. All other masters see ack/err/rty=0 and dat=0.
  - Grant holds while the granted wbm_cyc_i is high; pipelined bursts are never interrupted.
  - When the granted cyc drops: go to IDLE, set rr pointer to granted+1 (wrap), clear grant_o.
  - This forces at least one idle cycle between grants and guarantees fairness: worst-case wait is NUM_MASTERS-1 bus cycles.
- Watchdog (TIMEOUT_CYCLES>0):
  - Counter width is clog2(TIMEOUT_CYCLES)+1.
  - Cleared when not in BUSY, when granted stb=0, or when any of ack/err/rty is high.
  - Otherwise increments by 1 per cycle.
  - When it reaches TIMEOUT_CYCLES-1 with no response that cycle, go to ABORT.
- ABORT (exactly 1 cycle):
  - wbs_cyc_o=0, wbs_stb_o=0, granted wbm_err_o=1, timeout_o=1, counter cleared.
  - If the granted cyc is still high, return to BUSY with the same grant; otherwise go to IDLE with the rr update.
  - A late slave ack arriving in ABORT is ignored and not forwarded.
- Simultaneous events:
  - A response arriving in the cycle the count would expire wins; there is no abort and the counter clears.
  - A new request in the cycle the grant releases is considered only from IDLE on the next cycle.
- Masters that drop cyc without being granted are simply never served; there is no latching of requests.

Decomposition:
- Shared package wb_arb_pkg holds:
  - state enum: IDLE, BUSY, ABORT;
  - WB_AW=32, WB_DW=32, WB_SW=4;
  - function rr_pick(req, ptr), returning a one-hot grant.
- One sub-module, wb_arb_watchdog: counter plus expiry compare, with ports clk, rst, clr, en and expire.

Test Plan:
- Single master 0 read:
  - Stimulus: cyc/stb at 0x80000010, slave acks 2 cycles later with 0xDEADBEEF.
  - Required: grant_o=01 one cycle after cyc; wbm_dat_o[31:0]=0xDEADBEEF with ack[0]=1; ack[1]=0.
- Contention:
  - Stimulus: both masters raise cyc in the same cycle, from reset.
  - Required: master 0 granted first; after its cyc drops, one IDLE cycle, then grant_o=10.
  - Stimulus: repeat the contention.
  - Required: master 0 granted again, since the pointer has returned to 0.
- Burst hold:
  - Stimulus: master 1 holds cyc for 4 acked stb beats while master 0 requests.
  - Required: grant_o stays 10 for all 4 beats; master 0 receives no ack.
- Timeout:
  - Setup: TIMEOUT_CYCLES=8; slave never acks.
  - Required: at 8 cycles of stb, timeout_o=1 and wbm_err_o[0]=1 for 1 cycle; wbs_cyc_o=0 that cycle.
  - Follow-up: master drops cyc. Required: state IDLE.
- Race:
  - Stimulus: ack arrives in cycle 8 of stb with TIMEOUT_CYCLES=8.
  - Required: normal ack, no err, timeout_o=0.
- Reset mid-transfer:
  - Stimulus: assert wb_rst_i during a BUSY cycle.
  - Required: next cycle grant_o=0, wbs_cyc_o=0, all responses 0.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// ============================================================================
// Module      : wb_arb_pkg
// Description : Shared types, bus widths and round-robin pick function for the
//               Wishbone master arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_arb_pkg;

   localparam int WB_AW       = 32;
   localparam int WB_DW       = 32;
   localparam int WB_SW       = 4;
   localparam int MAX_MASTERS = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      ABORT = 2'd2
   } arb_state_t;

   // Unused upper request bits must be zero; then a modulo-8 scan from ptr
   // selects the same master as a modulo-NUM_MASTERS scan would.
   function automatic logic [MAX_MASTERS-1:0] rr_pick(
      input logic [MAX_MASTERS-1:0] req,
      input logic [2:0]             ptr
   );
      logic [MAX_MASTERS-1:0] g;
      logic [2:0]             idx;
      logic                   found;
      g     = '0;
      found = 1'b0;
      for (int i = 0; i < MAX_MASTERS; i++) begin
         idx = ptr + 3'(i);
         if (!found && req[idx]) begin
            g[idx] = 1'b1;
            found  = 1'b1;
         end
      end
      return g;
   endfunction

endpackage

`default_nettype wire

// File: rtl/wb_arb_watchdog.sv
// ============================================================================
// Module      : wb_arb_watchdog
// Description : Counts unanswered strobe cycles and flags expiry one cycle
//               before the abort state is entered.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_arb_watchdog #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expire
);

   generate
      if (TIMEOUT_CYCLES > 0) begin : g_wdt
         localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
         logic [CW-1:0] r_cnt;

         always_ff @(posedge clk) begin
            if (rst || clr) begin
               r_cnt <= '0;
            end else if (en) begin
               r_cnt <= r_cnt + 1'b1;
            end
         end

         // A response in the expiring cycle arrives through clr and wins.
         assign expire = en && !clr && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
      end else begin : g_no_wdt
         logic w_unused_ok;
         assign w_unused_ok = &{1'b0, clk, rst, clr, en};
         assign expire      = 1'b0;
      end
   endgenerate

endmodule

`default_nettype wire

// File: rtl/wb_master_arbiter.sv
// ============================================================================
// Module      : wb_master_arbiter
// Description : Round-robin arbiter sharing one Wishbone master port between
//               NUM_MASTERS requesters, with a watchdog that aborts dead slaves.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_master_arbiter
   import wb_arb_pkg::*;
#(
   parameter int NUM_MASTERS    = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                         wb_clk_i,
   input  logic                         wb_rst_i,
   input  logic [NUM_MASTERS*WB_AW-1:0] wbm_adr_i,
   input  logic [NUM_MASTERS*WB_DW-1:0] wbm_dat_i,
   input  logic [NUM_MASTERS*WB_SW-1:0] wbm_sel_i,
   input  logic [NUM_MASTERS-1:0]       wbm_we_i,
   input  logic [NUM_MASTERS-1:0]       wbm_cyc_i,
   input  logic [NUM_MASTERS-1:0]       wbm_stb_i,
   output logic [NUM_MASTERS*WB_DW-1:0] wbm_dat_o,
   output logic [NUM_MASTERS-1:0]       wbm_ack_o,
   output logic [NUM_MASTERS-1:0]       wbm_err_o,
   output logic [NUM_MASTERS-1:0]       wbm_rty_o,
   output logic [WB_AW-1:0]             wbs_adr_o,
   output logic [WB_DW-1:0]             wbs_dat_o,
   output logic [WB_SW-1:0]             wbs_sel_o,
   output logic                         wbs_we_o,
   output logic                         wbs_cyc_o,
   output logic                         wbs_stb_o,
   input  logic [WB_DW-1:0]             wbs_dat_i,
   input  logic                         wbs_ack_i,
   input  logic                         wbs_err_i,
   input  logic                         wbs_rty_i,
   output logic [NUM_MASTERS-1:0]       grant_o,
   output logic                         timeout_o
);

   arb_state_t             r_state, w_state_nxt;
   logic [NUM_MASTERS-1:0] r_grant, w_grant_nxt;
   logic [2:0]             r_gidx, w_gidx_nxt;
   logic [2:0]             r_ptr, w_ptr_nxt;
   logic [2:0]             w_pick_idx, w_ptr_rel;
   logic [MAX_MASTERS-1:0] w_req, w_pick;
   logic [WB_AW-1:0]       w_adr_g;
   logic [WB_DW-1:0]       w_dat_g;
   logic [WB_SW-1:0]       w_sel_g;
   logic                   w_we_g, w_cyc_g, w_stb_g;
   logic                   w_busy, w_resp, w_expire;

   // Granted master's request signals and the round-robin candidate.
   always_comb begin
      w_adr_g    = '0;
      w_dat_g    = '0;
      w_sel_g    = '0;
      w_we_g     = 1'b0;
      w_cyc_g    = 1'b0;
      w_stb_g    = 1'b0;
      w_req      = '0;
      w_req[NUM_MASTERS-1:0] = wbm_cyc_i;
      w_pick     = rr_pick(w_req, r_ptr);
      w_pick_idx = 3'd0;
      for (int i = 0; i < MAX_MASTERS; i++) begin
         if (w_pick[i]) w_pick_idx = 3'(i);
      end
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (r_gidx == 3'(i)) begin
            w_adr_g = wbm_adr_i[WB_AW*i +: WB_AW];
            w_dat_g = wbm_dat_i[WB_DW*i +: WB_DW];
            w_sel_g = wbm_sel_i[WB_SW*i +: WB_SW];
            w_we_g  = wbm_we_i[i];
            w_cyc_g = wbm_cyc_i[i];
            w_stb_g = wbm_stb_i[i];
         end
      end
   end

   assign w_busy    = (r_state == BUSY);
   assign w_resp    = wbs_ack_i | wbs_err_i | wbs_rty_i;
   assign w_ptr_rel = (r_gidx == 3'(NUM_MASTERS - 1)) ? 3'd0 : r_gidx + 3'd1;

   wb_arb_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk    (wb_clk_i),
      .rst    (wb_rst_i),
      .clr    (!w_busy || !w_stb_g || w_resp),
      .en     (w_busy),
      .expire (w_expire)
   );

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_state <= IDLE;
         r_grant <= '0;
         r_gidx  <= 3'd0;
         r_ptr   <= 3'd0;
      end else begin
         r_state <= w_state_nxt;
         r_grant <= w_grant_nxt;
         r_gidx  <= w_gidx_nxt;
         r_ptr   <= w_ptr_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_gidx_nxt  = r_gidx;
      w_ptr_nxt   = r_ptr;
      case (r_state)
         IDLE: begin
            if (|wbm_cyc_i) begin
               w_state_nxt = BUSY;
               w_grant_nxt = w_pick[NUM_MASTERS-1:0];
               w_gidx_nxt  = w_pick_idx;
            end
         end
         BUSY, ABORT: begin
            if (!w_cyc_g) begin
               w_state_nxt = IDLE;
               w_grant_nxt = '0;
               w_ptr_nxt   = w_ptr_rel;
            end else if (r_state == ABORT) begin
               w_state_nxt = BUSY;
            end else if (w_expire) begin
               w_state_nxt = ABORT;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_grant_nxt = '0;
         end
      endcase
   end

   // Slave-side copies exist only in BUSY; ABORT deliberately drops cyc/stb.
   always_comb begin
      wbs_adr_o = '0;
      wbs_dat_o = '0;
      wbs_sel_o = '0;
      wbs_we_o  = 1'b0;
      wbs_cyc_o = 1'b0;
      wbs_stb_o = 1'b0;
      wbm_dat_o = '0;
      wbm_ack_o = '0;
      wbm_err_o = '0;
      wbm_rty_o = '0;
      if (w_busy) begin
         wbs_adr_o = w_adr_g;
         wbs_dat_o = w_dat_g;
         wbs_sel_o = w_sel_g;
         wbs_we_o  = w_we_g;
         wbs_cyc_o = w_cyc_g;
         wbs_stb_o = w_stb_g;
      end
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (r_gidx == 3'(i)) begin
            if (w_busy) begin
               wbm_dat_o[WB_DW*i +: WB_DW] = wbs_dat_i;
               wbm_ack_o[i] = wbs_ack_i;
               wbm_err_o[i] = wbs_err_i;
               wbm_rty_o[i] = wbs_rty_i;
            end else if (r_state == ABORT) begin
               wbm_err_o[i] = 1'b1;
            end
         end
      end
   end

   assign grant_o   = r_grant;
   assign timeout_o = (r_state == ABORT);

endmodule

`default_nettype wire

// File: tb/tb_wb_master_arbiter.sv
// ============================================================================
// Module      : tb_wb_master_arbiter
// Description : Directed self-checking bench for wb_master_arbiter with two
//               masters and an 8-cycle watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_master_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] adr, dat;
   logic [7:0]  sel;
   logic [1:0]  we, cyc, stb;
   logic [63:0] mdat;
   logic [1:0]  mack, merr, mrty;
   logic [31:0] sadr, sdat_o, sdat_i;
   logic [3:0]  ssel;
   logic        swe, scyc, sstb, sack, serr, srty;
   logic [1:0]  grant;
   logic        tmo;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   wb_master_arbiter #(
      .NUM_MASTERS    (2),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (rst),
      .wbm_adr_i (adr),
      .wbm_dat_i (dat),
      .wbm_sel_i (sel),
      .wbm_we_i  (we),
      .wbm_cyc_i (cyc),
      .wbm_stb_i (stb),
      .wbm_dat_o (mdat),
      .wbm_ack_o (mack),
      .wbm_err_o (merr),
      .wbm_rty_o (mrty),
      .wbs_adr_o (sadr),
      .wbs_dat_o (sdat_o),
      .wbs_sel_o (ssel),
      .wbs_we_o  (swe),
      .wbs_cyc_o (scyc),
      .wbs_stb_o (sstb),
      .wbs_dat_i (sdat_i),
      .wbs_ack_i (sack),
      .wbs_err_i (serr),
      .wbs_rty_i (srty),
      .grant_o   (grant),
      .timeout_o (tmo)
   );

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_time_limit: observed=expired expected=finish");
      $fatal(1, "time limit");
   end

   initial begin
      rst = 1'b1; adr = '0; dat = '0; sel = '0; we = '0; cyc = '0; stb = '0;
      sdat_i = '0; sack = 1'b0; serr = 1'b0; srty = 1'b0;
      step(); step();
      chk("rst_grant",   64'(grant), 0);
      chk("rst_wbs_cyc", 64'(scyc), 0);
      chk("rst_ack",     64'(mack), 0);
      chk("rst_dat",     mdat, 0);
      chk("rst_timeout", 64'(tmo), 0);
      rst = 1'b0;

      // single master 0 read
      adr[31:0] = 32'h8000_0010; adr[63:32] = 32'h1000_0000; sel = 8'hFF;
      cyc[0] = 1'b1; stb[0] = 1'b1; #1;
      chk("idle_wbs_cyc", 64'(scyc), 0);
      step();
      chk("rd_grant", 64'(grant), 64'h1);
      chk("rd_adr",   64'(sadr), 64'h8000_0010);
      chk("rd_cyc",   64'(scyc), 1);
      step();
      sack = 1'b1; sdat_i = 32'hDEAD_BEEF; #1;
      chk("rd_ack",    64'(mack), 64'h1);
      chk("rd_dat0",   64'(mdat[31:0]), 64'hDEAD_BEEF);
      chk("rd_dat1",   64'(mdat[63:32]), 0);
      step();
      sack = 1'b0; cyc[0] = 1'b0; stb[0] = 1'b0; #1;
      chk("rd_drop_cyc", 64'(scyc), 0);
      step();
      chk("rd_release", 64'(grant), 0);

      // contention from reset
      rst = 1'b1; step(); rst = 1'b0;
      cyc = 2'b11; stb = 2'b11;
      step();
      chk("ct_grant0", 64'(grant), 64'h1);
      chk("ct_adr0",   64'(sadr), 64'h8000_0010);
      sack = 1'b1; #1;
      chk("ct_ack0", 64'(mack), 64'h1);
      step();
      sack = 1'b0; cyc[0] = 1'b0; stb[0] = 1'b0;
      step();
      chk("ct_idle_gap", 64'(grant), 0);
      step();
      chk("ct_grant1", 64'(grant), 64'h2);
      chk("ct_adr1",   64'(sadr), 64'h1000_0000);
      sack = 1'b1; #1;
      chk("ct_ack1", 64'(mack), 64'h2);
      step();
      sack = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0;
      step();
      chk("ct_idle2", 64'(grant), 0);

      // repeated contention: pointer wrapped back to 0
      cyc = 2'b11; stb = 2'b11;
      step();
      chk("ct_wrap_grant0", 64'(grant), 64'h1);
      cyc[0] = 1'b0; stb[0] = 1'b0;
      step(); step();
      chk("bu_grant1", 64'(grant), 64'h2);

      // burst hold on master 1 while master 0 requests
      cyc[0] = 1'b1; stb[0] = 1'b1;
      for (int b = 0; b < 4; b++) begin
         sack = 1'b1; sdat_i = 32'h0000_0100 + 32'(b); #1;
         chk("bu_grant", 64'(grant), 64'h2);
         chk("bu_ack",   64'(mack), 64'h2);
         chk("bu_dat1",  64'(mdat[63:32]), 64'h0000_0100 + 64'(b));
         step();
      end
      sack = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0;
      step();
      chk("bu_idle", 64'(grant), 0);
      step();
      chk("bu_then_m0", 64'(grant), 64'h1);
      cyc = '0; stb = '0;
      step();
      chk("bu_end_idle", 64'(grant), 0);

      // watchdog timeout, slave never answers
      cyc[0] = 1'b1; stb[0] = 1'b1;
      step();
      repeat (7) step();
      chk("to_pre_tmo", 64'(tmo), 0);
      chk("to_pre_err", 64'(merr), 0);
      step();
      sack = 1'b1; #1;
      chk("to_tmo",     64'(tmo), 1);
      chk("to_err",     64'(merr), 64'h1);
      chk("to_cyc",     64'(scyc), 0);
      chk("to_stb",     64'(sstb), 0);
      chk("to_late_ack",64'(mack), 0);
      chk("to_grant",   64'(grant), 64'h1);
      step();
      sack = 1'b0; #1;
      chk("to_back_tmo", 64'(tmo), 0);
      chk("to_back_err", 64'(merr), 0);
      chk("to_back_cyc", 64'(scyc), 1);
      cyc = '0; stb = '0;
      step();
      chk("to_idle_grant", 64'(grant), 0);
      chk("to_idle_cyc",   64'(scyc), 0);

      // response in the expiring cycle wins
      cyc[0] = 1'b1; stb[0] = 1'b1;
      step();
      repeat (6) step();
      step();
      sack = 1'b1; sdat_i = 32'h1234_5678; #1;
      chk("race_ack", 64'(mack), 64'h1);
      chk("race_err", 64'(merr), 0);
      chk("race_tmo", 64'(tmo), 0);
      chk("race_dat", 64'(mdat[31:0]), 64'h1234_5678);
      step();
      sack = 1'b0; #1;
      chk("race_after_tmo", 64'(tmo), 0);
      chk("race_after_cyc", 64'(scyc), 1);
      repeat (6) step();
      chk("race_cnt_cleared", 64'(tmo), 0);

      // reset mid-transfer
      rst = 1'b1; sack = 1'b1;
      step();
      chk("mr_grant", 64'(grant), 0);
      chk("mr_cyc",   64'(scyc), 0);
      chk("mr_stb",   64'(sstb), 0);
      chk("mr_ack",   64'(mack), 0);
      chk("mr_err",   64'(merr), 0);
      chk("mr_tmo",   64'(tmo), 0);
      rst = 1'b0; sack = 1'b0; cyc = '0; stb = '0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
